// File: rtl/latch_phase_sequencer_pkg.sv
// rtl/latch_phase_sequencer_pkg.sv - shared state encodings and default widths
// Holds the 3-bit FSM encoding and the default datapath/timer widths.
package latch_phase_sequencer_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M_ON = 3'd1,
    ST_GAP1 = 3'd2,
    ST_S_ON = 3'd3,
    ST_GAP2 = 3'd4
  } seq_state_t;

endpackage

// File: rtl/latch_phase_sequencer_if.sv
// rtl/latch_phase_sequencer_if.sv - request/config/latch-enable bundle
// The master side issues transfers; the sequencer is the slave side.
interface latch_phase_sequencer_if
  import latch_phase_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
);
  logic              start;
  logic [DATA_W-1:0] din;
  logic [CNT_W-1:0]  pulse_cyc;
  logic [CNT_W-1:0]  gap_cyc;
  logic [DATA_W-1:0] latch_d;
  logic              le_master;
  logic              le_slave;
  logic              busy;
  logic              done;

  modport master (
    output start, din, pulse_cyc, gap_cyc,
    input  latch_d, le_master, le_slave, busy, done
  );

  modport slave (
    input  start, din, pulse_cyc, gap_cyc,
    output latch_d, le_master, le_slave, busy, done
  );
endinterface

// File: rtl/latch_phase_sequencer_phase_timer.sv
// rtl/latch_phase_sequencer_phase_timer.sv - per-phase down-counter
// Loading N leaves N-1 in the counter so a phase lasts N cycles; 0 is clamped to 1.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val == '0) ? '0 : load_val - CNT_W'(1);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);
endmodule

// File: rtl/latch_phase_sequencer.sv
// rtl/latch_phase_sequencer.sv - non-overlapping master/slave latch enable sequencer
// Captures data and phase lengths on START, then walks M_ON, GAP1, S_ON, GAP2.
module latch_phase_sequencer
  import latch_phase_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic                    CLK,
  input logic                    RST_N,
  latch_phase_sequencer_if.slave bus
);
  seq_state_t       state, next_state;
  logic [CNT_W-1:0] p_reg, g_reg;
  logic [CNT_W-1:0] t_val;
  logic             t_load, t_expired;
  logic             accept, finish;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (t_load),
    .load_val (t_val),
    .expired  (t_expired)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= next_state;
  end

  // The GAP2 expiry edge doubles as an IDLE acceptance so back-to-back transfers lose no cycle.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    finish     = 1'b0;
    t_load     = 1'b0;
    t_val      = p_reg;
    case (state)
      ST_IDLE: if (bus.start) begin
        accept     = 1'b1;
        next_state = ST_M_ON;
        t_load     = 1'b1;
        t_val      = bus.pulse_cyc;
      end
      ST_M_ON: if (t_expired) begin
        next_state = ST_GAP1;
        t_load     = 1'b1;
        t_val      = g_reg;
      end
      ST_GAP1: if (t_expired) begin
        next_state = ST_S_ON;
        t_load     = 1'b1;
        t_val      = p_reg;
      end
      ST_S_ON: if (t_expired) begin
        next_state = ST_GAP2;
        t_load     = 1'b1;
        t_val      = g_reg;
      end
      ST_GAP2: if (t_expired) begin
        finish = 1'b1;
        if (bus.start) begin
          accept     = 1'b1;
          next_state = ST_M_ON;
          t_load     = 1'b1;
          t_val      = bus.pulse_cyc;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they change on the same edge as the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.latch_d   <= '0;
      p_reg         <= '0;
      g_reg         <= '0;
      bus.le_master <= 1'b0;
      bus.le_slave  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      if (accept) begin
        bus.latch_d <= bus.din;
        p_reg       <= bus.pulse_cyc;
        g_reg       <= bus.gap_cyc;
      end
      bus.le_master <= (next_state == ST_M_ON);
      bus.le_slave  <= (next_state == ST_S_ON);
      bus.busy      <= (next_state != ST_IDLE);
      bus.done      <= finish;
    end
  end
endmodule
